// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the rr_arb_4 round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_MAX_HOLD = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_4_pick.sv
// Combinational rotating-priority picker: rotate by ptr, take lowest set bit, rotate back.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_idx,
    output logic          any
);

    logic [N-1:0]  cand;
    logic [N-1:0]  rot;
    logic [PW-1:0] sel;

    // Modulo-N add without a divider; both operands are already below N.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
        return s[PW-1:0];
    endfunction

    always_comb begin
        cand = req & ~excl;
        rot  = '0;
        for (int i = 0; i < N; i++) rot[i] = cand[wrap_add(ptr, PW'(i))];
        any = |rot;
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) sel = PW'(i);
        end
        pick_idx = wrap_add(ptr, sel);
        pick     = '0;
        if (any) pick[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arb_4.sv
// Round-robin arbiter with registered one-hot grant and MAX_HOLD preemption.
// Define RR_ARB_GNT_ID_EN to add the registered binary owner index output gnt_id.
module rr_arb_4
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic         preempt
`ifdef RR_ARB_GNT_ID_EN
    ,
    output logic [clog2(N)-1:0] gnt_id
`endif
);

    localparam int PW = clog2(N);
    localparam int HW = clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [PW-1:0] own, own_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N-1:0]  gnt_n;
    logic          preempt_n;

    logic [PW-1:0] nxt_ptr;
    logic [PW-1:0] pick_ptr;
    logic [N-1:0]  excl;
    logic [N-1:0]  pick;
    logic [PW-1:0] pick_idx;
    logic          any;

    // While granting, search from owner+1 and mask the owner out; a releasing
    // owner has req low anyway, so the mask only matters for preemption.
    assign nxt_ptr  = (own == PW'(N - 1)) ? '0 : own + PW'(1);
    assign pick_ptr = (state == GRANT) ? nxt_ptr : ptr;
    assign excl     = (state == GRANT) ? gnt : '0;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .excl     (excl),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        own_n     = own;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    gnt_n   = pick;
                    own_n   = pick_idx;
                    hold_n  = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[own]) begin
                    if (hold_cnt < HOLD_LAST) begin
                        hold_n = hold_cnt + HW'(1);
                    end else if (any) begin
                        ptr_n     = nxt_ptr;
                        gnt_n     = pick;
                        own_n     = pick_idx;
                        hold_n    = '0;
                        preempt_n = 1'b1;
                    end else begin
                        hold_n = '0;
                    end
                end else begin
                    ptr_n  = nxt_ptr;
                    hold_n = '0;
                    if (any) begin
                        gnt_n = pick;
                        own_n = pick_idx;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            own       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            own       <= own_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_valid <= |gnt_n;
            preempt   <= preempt_n;
        end
    end

`ifdef RR_ARB_GNT_ID_EN
    assign gnt_id = own;
`endif

endmodule

// File: tb/tb_rr_arb_4.sv
// Scoreboard bench for rr_arb_4: a rule-level arbiter model feeds expected grants to a monitor.
module tb_rr_arb_4;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         preempt;
`ifdef RR_ARB_GNT_ID_EN
    logic [1:0]   gnt_id;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N-1:0] gnt;
        logic         pre;
        int           id;
    } exp_t;

    exp_t sb[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_id    = 0;

    rr_arb_4 #(
        .N        (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
`ifdef RR_ARB_GNT_ID_EN
        ,
        .gnt_id    (gnt_id)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester at or after 'start' (mod N), ignoring 'skip'; -1 if none.
    function automatic int search(input logic [N-1:0] r, input int start, input int skip);
        int k;
        for (int j = 0; j < N; j++) begin
            k = (start + j) % N;
            if (r[k] && k != skip) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        exp_t e;
        int   w;
        e.pre = 1'b0;
        if (m_owner < 0) begin
            m_owner = search(req, m_ptr, -1);
            m_cnt   = 0;
        end else if (req[m_owner]) begin
            if (m_cnt < MAXH - 1) begin
                m_cnt++;
            end else begin
                w = search(req, (m_owner + 1) % N, m_owner);
                if (w >= 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = w;
                    e.pre   = 1'b1;
                end
                m_cnt = 0;
            end
        end else begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = search(req, m_ptr, -1);
            m_cnt   = 0;
        end
        if (m_owner >= 0) m_id = m_owner;
        e.gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e.id  = m_id;
        sb.push_back(e);
    endtask

    // Reference model: advances at every active edge, resets asynchronously.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_ptr   = 0;
                m_cnt   = 0;
                m_id    = 0;
                sb.delete();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: compares registered outputs on the falling edge.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
            if (!rst_n) begin
                check("rst_gnt", 32'(gnt), 32'd0);
                check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
                check("rst_preempt", 32'(preempt), 32'd0);
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("gnt_valid", 32'(gnt_valid), 32'(e.gnt != '0));
                check("preempt", 32'(preempt), 32'(e.pre));
`ifdef RR_ARB_GNT_ID_EN
                check("gnt_id", 32'(gnt_id), 32'(e.id));
`endif
            end
        end
    end

    task automatic hold(input logic [N-1:0] r, input int cycles);
        req = r;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single requester grant and release
        hold(4'b0001, 3);
        hold(4'b0000, 2);

        // Same-edge requests, then back-to-back handover
        hold(4'b1010, 3);
        hold(4'b1000, 3);
        hold(4'b0000, 2);

        // Full contention: rotation with MAX_HOLD preemption
        hold(4'b1111, 70);

        // Lone requester beyond MAX_HOLD: no preemption
        hold(4'b0100, 20);

        // Owner 3, then asynchronous reset mid-cycle
        hold(4'b1000, 4);
        check("t5_owner3", 32'(gnt), 32'b1000);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("async_rst_preempt", 32'(preempt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        hold(4'b1001, 1);
        check("t5_after_rst", 32'(gnt), 32'b0001);
        hold(4'b1001, 2);
        hold(4'b0000, 2);

        // Random run with sticky requests so holds can reach MAX_HOLD
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            @(negedge clk);
        end
        hold(4'b0000, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
